// File: rtl/multu_hilo_pkg.sv
// Shared execute-stage definitions: 6-bit funct codes used by the ALU and the
// multiplier, plus the multiplier's controller state type.
package multu_hilo_pkg;

  localparam logic [5:0] FUNCT_SLL   = 6'b000000;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mul_state_e;

endpackage

// File: rtl/multu_hilo_hilo_reg.sv
// Architectural HI/LO register pair with write enable and async clear; also
// owns the MFHI/MFLO read mux feeding the execute result path.
module hilo_reg
  import multu_hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [5:0]       funct_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (we_i) begin
      hi_q <= hi_i;
      lo_q <= lo_i;
    end
  end

  always_comb begin
    rdata_o = '0;
    case (funct_i)
      FUNCT_MFHI: rdata_o = hi_q;
      FUNCT_MFLO: rdata_o = lo_q;
      default:    rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/multu_hilo.sv
// Sequential WIDTHxWIDTH unsigned shift-add multiplier: one partial-product bit
// per cycle for WIDTH cycles, result committed to HI/LO on the final step.
module multu_hilo
  import multu_hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic [WIDTH-1:0] dataOut,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  mul_state_e         state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               done_q, done_d;

  logic               start;
  logic               last;
  logic               hilo_we;
  logic [WIDTH:0]     sum;

  assign start = (Signal == FUNCT_MULTU);
  assign last  = (cnt_q == CNT_LAST);
  // Carry out of the upper-half add is kept and shifted into the top bit.
  assign sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          mcand_d = dataA;
          prod_d  = {{WIDTH{1'b0}}, dataB};
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        prod_d = {sum, prod_q[WIDTH-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q == ST_RUN);
    hilo_we = (state_q == ST_RUN) && last;
    done_d  = hilo_we;
  end

  assign done = done_q;

  hilo_reg #(
    .WIDTH(WIDTH)
  ) u_hilo_reg (
    .clk_i   (clk),
    .rst_ni  (reset),
    .we_i    (hilo_we),
    .hi_i    (prod_d[2*WIDTH-1:WIDTH]),
    .lo_i    (prod_d[WIDTH-1:0]),
    .funct_i (Signal),
    .rdata_o (dataOut)
  );

endmodule

// File: tb/tb_multu_hilo.sv
// Self-checking bench for multu_hilo: directed vector table, hand-written
// multi-cycle sequences and randomized operands against a plain-multiply model.
module tb_multu_hilo;
  import multu_hilo_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] dataA = '0;
  logic [31:0] dataB = '0;
  logic [5:0]  Signal = FUNCT_SLL;
  logic [31:0] dataOut;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vt[6];

  multu_hilo #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .dataA   (dataA),
    .dataB   (dataB),
    .Signal  (Signal),
    .dataOut (dataOut),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] wa;
    logic [63:0] wb;
    wa = {32'd0, a};
    wb = {32'd0, b};
    return wa * wb;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Reads HI, LO and one ignored code within the current cycle.
  task automatic read_check(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    logic [5:0] c;
    Signal = FUNCT_MFHI;
    #1 chk({tag, " MFHI"}, 64'(dataOut), 64'(hi));
    Signal = FUNCT_MFLO;
    #1 chk({tag, " MFLO"}, 64'(dataOut), 64'(lo));
    c = 6'($urandom_range(0, 63));
    if (c == FUNCT_MFHI || c == FUNCT_MFLO || c == FUNCT_MULTU) c = FUNCT_AND;
    Signal = c;
    #1 chk({tag, " other code"}, 64'(dataOut), 64'd0);
    Signal = FUNCT_SLL;
  endtask

  task automatic start_mul(input string tag, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    dataA  = a;
    dataB  = b;
    Signal = FUNCT_MULTU;
    @(posedge clk);
    #1;
    chk({tag, " busy after start"}, 64'(busy), 64'd1);
    chk({tag, " done after start"}, 64'(done), 64'd0);
    Signal = FUNCT_SLL;
    dataA  = $urandom;
    dataB  = $urandom;
  endtask

  // Counts edges from the start edge until busy falls; expects 32.
  task automatic wait_done(input string tag, input int already);
    int n;
    n = already;
    while (busy === 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, " busy cycles"}, 64'(n), 64'd32);
    chk({tag, " done pulse"}, 64'(done), 64'd1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] p;
    logic [31:0] ra;
    logic [31:0] rb;
    int n;

    vt[0] = '{32'd7, 32'd6, 32'd0, 32'd42};
    vt[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vt[2] = '{32'h80000000, 32'd2, 32'd1, 32'd0};
    vt[3] = '{32'd0, 32'h12345678, 32'd0, 32'd0};
    vt[4] = '{32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF};
    vt[5] = '{32'h00010000, 32'h00010000, 32'd1, 32'd0};

    // Reset state
    #2;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    read_check("reset", 32'd0, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed table
    for (int i = 0; i < 6; i++) begin
      start_mul($sformatf("vec%0d", i), vt[i].a, vt[i].b);
      wait_done($sformatf("vec%0d", i), 0);
      read_check($sformatf("vec%0d", i), vt[i].hi, vt[i].lo);
      @(posedge clk);
      #1 chk($sformatf("vec%0d done drop", i), 64'(done), 64'd0);
    end

    // Reads during busy return the previous product
    start_mul("prev", 32'h80000000, 32'd2);
    wait_done("prev", 0);
    start_mul("3x5", 32'd3, 32'd5);
    read_check("3x5 during busy", 32'd1, 32'd0);
    wait_done("3x5", 0);
    read_check("3x5 after", 32'd0, 32'd15);

    // MULTU held while busy is ignored
    @(negedge clk);
    dataA = 32'd9; dataB = 32'd9; Signal = FUNCT_MULTU;
    @(posedge clk);
    #1 chk("9x9 busy after start", 64'(busy), 64'd1);
    dataA = 32'd2; dataB = 32'd2;
    repeat (10) @(posedge clk);
    #1 Signal = FUNCT_SLL;
    wait_done("9x9 held", 10);
    read_check("9x9", 32'd0, 32'd81);

    // Reset mid-run aborts and clears HI/LO
    start_mul("100x100", 32'd100, 32'd100);
    repeat (12) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    read_check("abort", 32'd0, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 chk("abort stays idle", 64'(busy), 64'd0);
    read_check("abort idle", 32'd0, 32'd0);
    start_mul("4x4", 32'd4, 32'd4);
    wait_done("4x4", 0);
    read_check("4x4", 32'd0, 32'd16);

    // Back-to-back MULTU issued on the done cycle
    start_mul("b2b first", 32'd0, 32'h12345678);
    wait_done("b2b first", 0);
    read_check("b2b first", 32'd0, 32'd0);
    @(negedge clk);
    chk("b2b done at issue", 64'(done), 64'd1);
    dataA = 32'd6; dataB = 32'd7; Signal = FUNCT_MULTU;
    @(posedge clk);
    #1 chk("b2b accepted", 64'(busy), 64'd1);
    Signal = FUNCT_SLL;
    n = 0;
    wait_done("b2b second", n);
    read_check("b2b second", 32'd0, 32'd42);

    // Randomized operands against the arithmetic model
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 1) ra = 32'($urandom_range(0, 255));
      if (i % 4 == 2) rb = 32'hFFFFFFFF;
      p = ref_prod(ra, rb);
      start_mul($sformatf("rnd%0d", i), ra, rb);
      wait_done($sformatf("rnd%0d", i), 0);
      read_check($sformatf("rnd%0d %h*%h", i, ra, rb), p[63:32], p[31:0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multu_hilo.md
# multu_hilo

Sequential 32×32 unsigned shift-add multiplier with an architectural HI/LO register pair. It sits beside the ALU in the execute stage and drives the second input of the execute result mux. It uses the same 6-bit funct encoding as the ALU:
- MULTU starts a multiply.
- MFHI and MFLO read the stored product.

The controller stalls on `busy`.

## Interface
- `WIDTH`, 32, operand width; the product is 2·WIDTH bits.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `dataA`  in  WIDTH  multiplicand (rs).
- `dataB`  in  WIDTH  multiplier (rt).
- `Signal`  in  6  funct code: MULTU=6'b011001, MFHI=6'b010000, MFLO=6'b010010; all other codes are ignored.
- `dataOut`  out  WIDTH  combinational: HI when Signal=MFHI, LO when Signal=MFLO, otherwise 0.
- `busy`  out  1  high while a multiply is in progress.
- `done`  out  1  one-cycle pulse on the cycle after HI/LO is written.

## Operation
- States: IDLE, RUN.
- Registers:
  - `mcand[WIDTH-1:0]`
  - `prod[2·WIDTH-1:0]`
  - `cnt[$clog2(WIDTH)-1:0]`
  - `hi`, `lo`
- IDLE → RUN on a rising edge with Signal=MULTU.
  - Loads mcand←dataA, prod←{0, dataB}, cnt←0.
  - Sets busy←1.
- Each RUN edge:
  - Form sum = prod[63:32] + (prod[0] ? mcand : 0), 33 bits wide, carry kept.
  - Update prod ← {sum, prod[31:1]}, a 65→64-bit right shift that keeps the carry.
  - Increment cnt.
- RUN edge with cnt=WIDTH-1 (the 32nd RUN edge):
  - Writes hi←final prod[63:32] and lo←final prod[31:0] (values computed this edge).
  - Sets busy←0, done←1, state←IDLE.
- `done` returns to 0 on the next edge unless set again.
- Unsigned arithmetic only; no overflow exception; the full 64-bit product is always exact.
- MULTU while busy is ignored. Operands are not re-sampled and the count is not restarted.
- MFHI/MFLO while busy return the pre-multiply HI/LO. The controller must stall readers on busy.
- MULTU in the same cycle that `done` is high is accepted (back-to-back multiplies).
- dataA/dataB may change freely after the start edge; only the values sampled at the start edge matter.

## Timing
- Reset (asserted, asynchronous) values:
  - state=IDLE
  - busy=0, done=0
  - hi=0, lo=0, prod=0, mcand=0, cnt=0
  - dataOut=0 for any non-MF code
- Reset mid-RUN aborts immediately. HI/LO are cleared; there is no partial write.
- Latency: start edge E0; busy is high from E0 to E32; HI/LO are valid after E32; done is high in the cycle E32–E33.
- Throughput: one multiply per 33 cycles, counting the issue cycle.
- dataOut has zero-cycle latency from Signal and HI/LO; it is valid in the cycle after E32.

## Structure
- Shared package holds:
  - all funct constants: AND, OR, ADD, SUB, SLT, SLL, MULTU, MFHI, MFLO
  - the state typedef for IDLE/RUN
- The ALU and this block both import the package.
- One natural sub-module: `hilo_reg`. It is a 2×WIDTH register with write-enable and async active-low clear, and it owns the MFHI/MFLO read mux.
- The shift-add datapath and FSM stay in `multu_hilo`.

## Test plan
- dataA=7, dataB=6, MULTU for one cycle: busy high for 32 cycles, done pulse at cycle 33, then MFLO→42 and MFHI→0.
- dataA=dataB=32'hFFFFFFFF: MFHI→32'hFFFFFFFE, MFLO→32'h00000001 (exercises the carry-out path).
- Sequence:
  - Complete 32'h80000000×2, giving HI=1, LO=0.
  - Start 3×5; during busy, MFHI→1 and MFLO→0.
  - After done, MFLO→15 and MFHI→0.
- Start 9×9, then hold Signal=MULTU with dataA=dataB=2 for 10 more cycles: the result is LO=81 and busy falls exactly 32 cycles after the first start.
- Start 100×100, assert reset at RUN cycle 12, release: busy=0, done=0, MFLO→0, MFHI→0. A new 4×4 then gives LO=16.
- dataA=0, dataB=32'h12345678: MFLO→0, MFHI→0. A back-to-back MULTU issued on the done cycle is accepted.
